pid_pwm_actuator: RTL and testbench
===================================

// Module: pid_pwm_actuator
// PURPOSE
//  Consumer end of the PID control_out path. Accepts 8-bit duty words via valid/ready and
//  drives a single PWM output with 255-tick periods. Duty changes apply only at period
//  boundaries, rate-limited by a slew step. period_start is the controller's sample strobe.
// PARAMETERS
//  PRESCALE  4   clk cycles per PWM tick (>=1); 1 => one tick per clk
//  SLEW_MAX  16  max |change| of active duty per period (0 => unlimited, jump to target)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  reset, synchronous, active-high
//  enable        in   1  level; 1 = run PWM, 0 = stop after current period
//  duty_in       in   8  requested duty (0 = always low, 255 = always high)
//  duty_valid    in   1  duty_in valid; must hold until accepted
//  duty_ready    out  1  1 = pending slot empty; transfer on valid&ready at posedge
//  pwm_out       out  1  registered PWM output
//  period_start  out  1  1-clk pulse at start of every running period
//  duty_active   out  8  duty currently applied to pwm_out
//  running       out  1  1 while FSM in RUN or STOP
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, pwm_out=0, period_start=0, duty_active=0,
//   target=0, pending empty (duty_ready=1), prescaler=0, cnt=0, running=0. Mid-period reset
//   overrides all, including a same-cycle handshake (transfer is lost).
//  Handshake: duty_ready = ~pending_full (from register, no comb path from duty_valid).
//   valid&ready => pending<=duty_in, pending_full<=1. Accepted in any state.
//  Tick: prescaler counts 0..PRESCALE-1 in RUN/STOP only; tick=1 when prescaler==PRESCALE-1.
//   cnt advances on tick, 0..254 then wraps to 0 (wrap = tick & cnt==254).
//  Boundary update (at each wrap, and on IDLE->RUN entry):
//   1. if pending_full: target<=pending, pending_full<=0 (ready rises next cycle).
//   2. duty_active steps toward new target: diff=target-active (9-bit signed);
//      SLEW_MAX==0 or |diff|<=SLEW_MAX => active=target; else active+=/-SLEW_MAX. No overflow.
//   Word accepted in the same cycle as a wrap is NOT used at that wrap; it waits for the next.
//   Pending full at wrap and a valid this cycle: ready=0, word is held by source.
//  pwm_out <= (cnt < duty_active) in RUN/STOP, else 0. One-clk latency from cnt/duty_active.
//   duty 0 => never high; duty 255 => high for all 255 ticks.
//  period_start=1 for exactly one clk: the cycle after wrap, and the cycle after IDLE->RUN.
//  FSM:
//   IDLE: counters held 0, pwm_out=0. enable=1 -> RUN (cnt=0, boundary update).
//   RUN : enable=0 -> STOP; else run.
//   STOP: finish period; at wrap -> IDLE (no period_start, no update); enable=1 -> RUN (no restart).
//   Period never truncated by enable drop.
//  Simultaneous: wrap + enable fall => last period completes, STOP entered, then IDLE at next wrap.
// STRUCTURE
//  pid_pkg: DUTY_W=8, PERIOD_LAST=8'd254, state enum {ST_IDLE, ST_RUN, ST_STOP}.
//  Sub-module pwm_tick_gen: prescaler + 0..254 counter, outputs tick, wrap, cnt; clr input.
//  Top: FSM, pending/target/active registers, slew step, output register.
// TESTING (bench PRESCALE=1, SLEW_MAX=16 unless noted)
//  1. rst, enable=1, send duty 64 -> after first wrap active=16, then 32,48,64 on
//     successive periods; pwm_out high 64 clks of 255 from 4th period.
//  2. SLEW_MAX=0: send 200 while running -> duty_active=200 at next wrap, pwm high 200/255.
//  3. duty 0 and duty 255 -> pwm_out constant 0 / constant 1 across full periods.
//  4. Send 100 (accepted), then hold valid with 50 -> ready=0 until wrap; 50 accepted the
//     cycle after wrap; target=100 this wrap, 50 next wrap.
//  5. enable=0 at cnt=10 -> pwm continues to cnt=254, running falls after wrap, pwm_out=0,
//     no period_start; enable=1 again -> period_start pulse, cnt restarts at 0.
//  6. Assert rst at cnt=120 with valid&ready -> next cycle all outputs at reset values,
//     duty_ready=1, transfer dropped.

Source files
------------

// File: rtl/pid_pkg.sv
// Purpose: shared widths, PWM period constant, FSM state type and slew helper for the PWM actuator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pid_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] PERIOD_LAST = 8'd254;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    // Move act one slew step toward tgt; a zero slew means jump straight to tgt.
    // The step is only taken when |diff| exceeds slew, so the result never leaves 0..255.
    function automatic logic [DUTY_W-1:0] slew_step(
        input logic [DUTY_W-1:0] act,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W:0]   slew
    );
        logic [DUTY_W:0] diff;
        logic [DUTY_W:0] mag;
        diff = {1'b0, tgt} - {1'b0, act};
        mag  = diff[DUTY_W] ? ((DUTY_W+1)'(0) - diff) : diff;
        if ((slew == '0) || (mag <= slew)) begin
            slew_step = tgt;
        end else if (diff[DUTY_W]) begin
            slew_step = act - slew[DUTY_W-1:0];
        end else begin
            slew_step = act + slew[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pid_pwm_actuator_if.sv
// Purpose: duty-word valid/ready channel from the PID controller to the PWM actuator.
// Latency: n/a (wires only).
// Backpressure: source holds duty_in/duty_valid until duty_ready is seen at a clock edge.
interface pid_pwm_actuator_if;
    import pid_pkg::*;

    logic [DUTY_W-1:0] duty_in;
    logic              duty_valid;
    logic              duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/pwm_tick_gen.sv
// Purpose: PWM timebase -- prescaler feeding a 0..254 period counter, with a wrap strobe.
// Latency: wrap_o is combinational from the registered counters; counters update each tick.
// Backpressure: none; clr_i holds both counters at zero.
module pwm_tick_gen
    import pid_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              wrap_o,
    output logic [DUTY_W-1:0] cnt_o
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              tick;

    assign tick   = ~clr_i & (presc_q == PS_LAST);
    assign wrap_o = tick & (cnt_q == PERIOD_LAST);
    assign cnt_o  = cnt_q;

    // Next-state: prescaler rolls every PRESCALE clks, period counter advances per tick and wraps after 254.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            presc_d = tick ? '0 : (presc_q + PS_W'(1));
            if (tick) begin
                cnt_d = wrap_o ? '0 : (cnt_q + 8'd1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pid_pwm_actuator.sv
// Purpose: accepts duty words, applies them slew-limited at PWM period boundaries, drives pwm_out.
// Latency: pwm_out is registered, one clk behind cnt/duty_active; a new word takes effect at the next boundary.
// Backpressure: duty_ready drops while the single pending slot is full; it frees at the next boundary.
module pid_pwm_actuator
    import pid_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int SLEW_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    pid_pwm_actuator_if.slave        dif,
    output logic                     pwm_out,
    output logic                     period_start,
    output logic [DUTY_W-1:0]        duty_active,
    output logic                     running
);

    localparam logic [DUTY_W:0] SLEW_L = (DUTY_W+1)'(SLEW_MAX);

    state_t            state_q;
    logic [DUTY_W-1:0] pending_q;
    logic              pending_full_q;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic              pwm_q;
    logic              period_start_q;
    logic              running_q;

    logic              idle;
    logic              wrap;
    logic [DUTY_W-1:0] cnt;
    logic              xfer;

    assign idle           = (state_q == ST_IDLE);
    assign dif.duty_ready = ~pending_full_q;
    assign xfer           = dif.duty_valid & ~pending_full_q;

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign duty_active  = active_q;
    assign running      = running_q;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (idle),
        .wrap_o (wrap),
        .cnt_o  (cnt)
    );

    // Values a boundary update would load: pending word (if any) becomes target, active steps toward it.
    always_comb begin
        target_d = pending_full_q ? pending_q : target_q;
        active_d = slew_step(active_q, target_d, SLEW_L);
    end

    // Control FSM plus handshake slot, boundary update and registered outputs.
    // A word accepted on a wrap edge lands in pending after the boundary has already sampled it,
    // so it waits for the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            target_q       <= '0;
            active_q       <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            period_start_q <= 1'b0;
            pwm_q          <= ~idle & (cnt < active_q);

            if (xfer) begin
                pending_q      <= dif.duty_in;
                pending_full_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q        <= ST_RUN;
                        running_q      <= 1'b1;
                        period_start_q <= 1'b1;
                        target_q       <= target_d;
                        active_q       <= active_d;
                        if (pending_full_q) pending_full_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (wrap) begin
                        period_start_q <= 1'b1;
                        target_q       <= target_d;
                        active_q       <= active_d;
                        if (pending_full_q) pending_full_q <= 1'b0;
                    end
                    if (!enable) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (enable) begin
                        state_q <= ST_RUN;
                        if (wrap) begin
                            period_start_q <= 1'b1;
                            target_q       <= target_d;
                            active_q       <= active_d;
                            if (pending_full_q) pending_full_q <= 1'b0;
                        end
                    end else if (wrap) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Purpose: self-checking bench for pid_pwm_actuator; unit A uses SLEW_MAX=16, unit B SLEW_MAX=0.
// Latency: outputs sampled on the falling edge, half a clock after the registers update.
// Backpressure: duty source holds valid until ready is observed.
module tb_pid_pwm_actuator;
    import pid_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b;
    logic pwm_a, ps_a, run_a;
    logic pwm_b, ps_b, run_b;
    logic [7:0] act_a, act_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    always #5 clk = ~clk;

    pid_pwm_actuator_if a_if ();
    pid_pwm_actuator_if b_if ();

    pid_pwm_actuator #(.PRESCALE(1), .SLEW_MAX(16)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .dif(a_if.slave),
        .pwm_out(pwm_a), .period_start(ps_a), .duty_active(act_a), .running(run_a)
    );

    pid_pwm_actuator #(.PRESCALE(1), .SLEW_MAX(0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .dif(b_if.slave),
        .pwm_out(pwm_b), .period_start(ps_b), .duty_active(act_b), .running(run_b)
    );

    function automatic logic ps_of(input bit sel);
        return sel ? ps_b : ps_a;
    endfunction

    function automatic logic rdy_of(input bit sel);
        return sel ? b_if.duty_ready : a_if.duty_ready;
    endfunction

    task automatic drive_valid(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            b_if.duty_valid = v; b_if.duty_in = d;
        end else begin
            a_if.duty_valid = v; a_if.duty_in = d;
        end
    endtask

    // Present a word and hold it until the unit has taken it.
    task automatic send(input bit sel, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        drive_valid(sel, 1'b1, d);
        for (int i = 0; i < 600 && !ok; i++) begin
            if (rdy_of(sel)) ok = 1'b1;
            @(negedge clk);
        end
        drive_valid(sel, 1'b0, 8'd0);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept unit=%0d: ready never seen, required 1", sel);
        end
    endtask

    // Advance to the next period_start cycle, bounded.
    task automatic wait_ps(input bit sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps_of(sel) && n < 600);
        checks++;
        if (!ps_of(sel)) begin
            errors++;
            $display("FAIL wait_period_start unit=%0d: no pulse in %0d clks, required one", sel, n);
        end
    endtask

    // From a period_start cycle, count pwm highs over the 255 clks of that period; ends on the next start.
    task automatic measure(input bit sel, output int highs);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            highs += int'(sel ? pwm_b : pwm_a);
        end
        checks++;
        if (!ps_of(sel)) begin
            errors++;
            $display("FAIL period_len unit=%0d: period_start=%b after 255 clks, required 1", sel, ps_of(sel));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        drive_valid(1'b0, 1'b0, 8'd0);
        drive_valid(1'b1, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({pwm_a, ps_a, run_a, act_a, a_if.duty_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_a: pwm=%b ps=%b run=%b act=%0d rdy=%b, required 0 0 0 0 1",
                     pwm_a, ps_a, run_a, act_a, a_if.duty_ready);
        end
        checks++;
        if ({pwm_b, ps_b, run_b, act_b, b_if.duty_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_b: pwm=%b ps=%b run=%b act=%0d rdy=%b, required 0 0 0 0 1",
                     pwm_b, ps_b, run_b, act_b, b_if.duty_ready);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({run_a, ps_a, pwm_a} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold: run=%b ps=%b pwm=%b, required 000", run_a, ps_a, pwm_a);
        end
    endtask

    task automatic test_slew_ramp();
        logic [7:0] e;
        int h;
        en_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps_a, run_a, act_a} !== {1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL start_pulse: ps=%b run=%b act=%0d, required 1 1 0", ps_a, run_a, act_a);
        end
        send(1'b0, 8'd64);
        sb_a.push_back(8'd16); sb_a.push_back(8'd32);
        sb_a.push_back(8'd48); sb_a.push_back(8'd64);
        wait_ps(1'b0);
        repeat (4) begin
            e = sb_a.pop_front();
            checks++;
            if (act_a !== e) begin
                errors++;
                $display("FAIL ramp_active: got %0d, required %0d", act_a, e);
            end
            measure(1'b0, h);
            checks++;
            if (h != int'(e)) begin
                errors++;
                $display("FAIL ramp_pwm_highs: got %0d, required %0d", h, e);
            end
        end
    endtask

    task automatic test_no_slew();
        logic [7:0] e;
        int h;
        en_b = 1'b1;
        @(negedge clk);
        send(1'b1, 8'd200);
        sb_b.push_back(8'd200);
        wait_ps(1'b1);
        e = sb_b.pop_front();
        checks++;
        if (act_b !== e) begin
            errors++;
            $display("FAIL jump_active: got %0d, required %0d", act_b, e);
        end
        measure(1'b1, h);
        checks++;
        if (h != 200) begin
            errors++;
            $display("FAIL jump_pwm_highs: got %0d, required 200", h);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] d;
        logic [7:0] e;
        int h;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 8'd255 : 8'd0;
            send(1'b1, d);
            sb_b.push_back(d);
            wait_ps(1'b1);
            e = sb_b.pop_front();
            checks++;
            if (act_b !== e) begin
                errors++;
                $display("FAIL extreme_active: got %0d, required %0d", act_b, e);
            end
            repeat (2) begin
                measure(1'b1, h);
                checks++;
                if (h != int'(e)) begin
                    errors++;
                    $display("FAIL extreme_pwm_highs: got %0d, required %0d", h, e);
                end
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        bit rdy_seen;
        int n;
        drive_valid(1'b0, 1'b1, 8'd100);
        checks++;
        if (a_if.duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: got %b, required 1", a_if.duty_ready);
        end
        sb_a.push_back(8'd80);
        @(negedge clk);
        checks++;
        if (a_if.duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_slot_full: ready=%b, required 0", a_if.duty_ready);
        end
        drive_valid(1'b0, 1'b1, 8'd50);
        rdy_seen = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ps_a && a_if.duty_ready) rdy_seen = 1'b1;
        end while (!ps_a && n < 600);
        checks++;
        if (rdy_seen || !ps_a) begin
            errors++;
            $display("FAIL b2b_hold: ready_before_wrap=%b ps=%b, required 0 1", rdy_seen, ps_a);
        end
        e = sb_a.pop_front();
        checks++;
        if ({a_if.duty_ready, act_a} !== {1'b1, e}) begin
            errors++;
            $display("FAIL b2b_wrap: ready=%b act=%0d, required 1 %0d", a_if.duty_ready, act_a, e);
        end
        @(negedge clk);
        checks++;
        if (a_if.duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: ready=%b, required 0", a_if.duty_ready);
        end
        drive_valid(1'b0, 1'b0, 8'd0);
        sb_a.push_back(8'd64);
        wait_ps(1'b0);
        e = sb_a.pop_front();
        checks++;
        if (act_a !== e) begin
            errors++;
            $display("FAIL b2b_second_active: got %0d, required %0d", act_a, e);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] e;
        int h;
        int idx;
        bit ps_seen;
        bit idle_bad;
        h = 0;
        repeat (10) begin
            @(negedge clk);
            h += int'(pwm_a);
        end
        en_a = 1'b0;
        idx = 10;
        ps_seen = 1'b0;
        do begin
            @(negedge clk);
            idx++;
            h += int'(pwm_a);
            if (ps_a) ps_seen = 1'b1;
        end while (run_a && idx < 600);
        checks++;
        if (idx != 255 || ps_seen) begin
            errors++;
            $display("FAIL stop_timing: running fell at clk %0d ps_seen=%b, required 255 0", idx, ps_seen);
        end
        checks++;
        if (h != 64) begin
            errors++;
            $display("FAIL stop_full_period: highs=%0d, required 64", h);
        end
        idle_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pwm_a || ps_a || run_a) idle_bad = 1'b1;
        end
        checks++;
        if (idle_bad) begin
            errors++;
            $display("FAIL idle_quiet: activity seen=%b, required 0", idle_bad);
        end
        en_a = 1'b1;
        sb_a.push_back(8'd50);
        @(negedge clk);
        e = sb_a.pop_front();
        checks++;
        if ({ps_a, run_a, act_a} !== {1'b1, 1'b1, e}) begin
            errors++;
            $display("FAIL restart: ps=%b run=%b act=%0d, required 1 1 %0d", ps_a, run_a, act_a, e);
        end
        measure(1'b0, h);
        checks++;
        if (h != 50) begin
            errors++;
            $display("FAIL restart_pwm_highs: got %0d, required 50", h);
        end
    endtask

    task automatic test_reset_mid();
        repeat (120) @(negedge clk);
        drive_valid(1'b0, 1'b1, 8'd77);
        checks++;
        if (a_if.duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready_before: got %b, required 1", a_if.duty_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pwm_a, ps_a, run_a, act_a, a_if.duty_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_outputs: pwm=%b ps=%b run=%b act=%0d rdy=%b, required 0 0 0 0 1",
                     pwm_a, ps_a, run_a, act_a, a_if.duty_ready);
        end
        rst = 1'b0;
        drive_valid(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checks++;
        if ({ps_a, act_a} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL midrst_dropped: ps=%b act=%0d, required 1 0", ps_a, act_a);
        end
        en_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slew_ramp();
        test_no_slew();
        test_extremes();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
